timer_counter: RTL
==================

// Module: timer_counter
// PURPOSE
// - Memory-mapped countdown timer: the responder end of the CPU M-stage data bus (address, write enable, write data, read data).
// - The system bridge decodes the timer window, strobes this block, and muxes its rdata back into the CPU read path.
// - irq feeds one CPU hardware-interrupt input (HWInt[0] for TC0, HWInt[1] for TC1).
// PARAMETERS
// - RESET_PRESET  32'h0  reset value of the PRESET register
// PORTS
// - clk       in   1   system clock; all state updates on posedge
// - reset     in   1   asynchronous, active-high; clears all state immediately
// - addr      in   2   word select = bus address[3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
// - we        in   1   write strobe for the selected word; qualified by the bridge window decode
// - wdata     in   32  write data
// - rdata     out  32  read data; combinational from addr and current registers
// - irq       out  1   interrupt request; registered output
// BEHAVIOUR
// - Registers:
//   - CTRL[3] = IM (irq mask), CTRL[2:1] = MODE (00 one-shot, 01 auto-reload, 1x reserved, treated as 00), CTRL[0] = EN.
//   - CTRL[31:4] always read 0.
//   - PRESET is R/W, 32 bit. COUNT is read-only; writes to COUNT are ignored.
//   - Reads of addr 3 return 0; writes to addr 3 are ignored.
// - Reset: CTRL=0, PRESET=RESET_PRESET, COUNT=0, state=IDLE, irq_flag=0, irq=0. Reset mid-count abandons the count with no irq.
// - FSM (2-bit state):
//   - IDLE: EN=1 -> LOAD.
//   - LOAD: COUNT<=PRESET -> CNT.
//   - CNT: EN=0 -> IDLE, COUNT held. COUNT>1 -> COUNT-1. COUNT<=1 -> COUNT<=0, irq_flag<=1, -> INT.
//   - INT: MODE 00: EN<=0, -> IDLE, irq_flag held. MODE 01: irq_flag<=0, -> IDLE, then reloads while EN=1.
// - Latency: with EN set in cycle t, PRESET=N>=1, irq_flag rises at end of cycle t+1+N.
// - PRESET=0 counts as 1 tick.
// - irq <= IM & irq_flag, registered. Auto-reload therefore yields a one-cycle irq pulse.
// - A one-shot irq holds until any write to CTRL or PRESET, which clears irq_flag at that edge.
// - Simultaneous bus write and FSM update in the same cycle:
//   - The FSM uses pre-edge register values.
//   - The bus write to CTRL overrides the INT-state EN clear.
//   - A PRESET write during CNT does not affect the running COUNT; it applies at the next LOAD.
// - COUNT decrement is unsigned 32-bit. It never underflows: the floor is 0.
// STRUCTURE
// - Shared header timer_defs.vh holds:
//   - word offsets TC_CTRL=2'd0, TC_PRESET=2'd1, TC_COUNT=2'd2
//   - state codes IDLE/LOAD/CNT/INT
//   - MODE_ONESHOT/MODE_RELOAD
//   - CTRL bit indices
// - Single flat module, no sub-module. Register file and FSM share the write-enable decode.
// TESTING
// - Reset release, read addr 0/1/2/3 -> rdata 0,0,0,0 (RESET_PRESET=0); irq=0.
// - PRESET=5, CTRL=32'h9 (IM=1, one-shot, EN) -> COUNT reads 5,4,3,2,1,0.
//   - irq=1 from the edge after the flag rises; CTRL[0] reads 0.
//   - Writing CTRL=0 drops irq next cycle.
// - PRESET=3, CTRL=32'hB (auto-reload) -> irq one-cycle pulse every 6 cycles (LOAD+3 CNT+INT+IDLE), repeating for 4 periods.
// - CTRL=32'h1 (IM=0) with PRESET=2 -> irq stays 0.
//   - Then writing CTRL=32'h9 while irq_flag=1 clears the flag; irq stays 0.
// - Mid-count: PRESET=100, EN at t, assert reset at t+10 asynchronously -> COUNT=0, irq=0, CTRL=0 within the same cycle.
// - Write COUNT=32'hFFFF while counting -> ignored. Write CTRL EN=0 at COUNT=7 -> COUNT holds 7, state IDLE.
//   - Re-enable -> reloads PRESET.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped countdown timer.
// Holds the word offsets, CTRL bit layout, mode codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] TC_CTRL   = 2'd0;
  localparam logic [1:0] TC_PRESET = 2'd1;
  localparam logic [1:0] TC_COUNT  = 2'd2;

  localparam logic [1:0] MODE_RELOAD = 2'b01;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

  // CTRL occupies the low nibble; the upper bits always read as zero.
  function automatic logic [31:0] ctrl_word(input logic [CTRL_W-1:0] ctrl);
    return {28'd0, ctrl};
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// Responder-side data bus of the timer: word select, write strobe/data,
// read data and the interrupt request toward the CPU.
interface timer_counter_if;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  modport master (output addr, output we, output wdata, input rdata, input irq);
  modport slave  (input addr, input we, input wdata, output rdata, output irq);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer with one-shot and auto-reload modes.
// Register file and FSM share a single write decode and a single state process.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] RESET_PRESET = 32'h0
) (
  input  logic            i_clk,
  input  logic            i_reset,
  timer_counter_if.slave  bus
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [31:0]       r_preset;
  logic [31:0]       r_count;
  state_t            r_state;
  logic              r_irq_flag;
  logic              r_irq;

  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_en;
  logic w_reload;

  assign w_wr_ctrl   = bus.we && (bus.addr == TC_CTRL);
  assign w_wr_preset = bus.we && (bus.addr == TC_PRESET);
  assign w_en        = r_ctrl[CTRL_EN];
  // Reserved modes 1x fall back to one-shot behaviour.
  assign w_reload    = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  // Later assignments win: FSM updates override the bus-write flag clear,
  // and a same-edge CTRL write overrides the one-shot EN clear.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ctrl     <= {CTRL_W{1'b0}};
      r_preset   <= RESET_PRESET;
      r_count    <= 32'd0;
      r_state    <= ST_IDLE;
      r_irq_flag <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_irq <= r_ctrl[CTRL_IM] & r_irq_flag;

      if (w_wr_ctrl) begin
        r_ctrl <= bus.wdata[CTRL_W-1:0];
      end
      if (w_wr_preset) begin
        r_preset <= bus.wdata;
      end
      if (w_wr_ctrl || w_wr_preset) begin
        r_irq_flag <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_en) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!w_en) begin
            r_state <= ST_IDLE;
          end else if (r_count > 32'd1) begin
            r_count <= r_count - 32'd1;
          end else begin
            r_count    <= 32'd0;
            r_irq_flag <= 1'b1;
            r_state    <= ST_INT;
          end
        end
        ST_INT: begin
          if (w_reload) begin
            r_irq_flag <= 1'b0;
          end else if (!w_wr_ctrl) begin
            r_ctrl[CTRL_EN] <= 1'b0;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux follows the word select combinationally.
  always_comb begin
    bus.rdata = 32'd0;
    case (bus.addr)
      TC_CTRL:   bus.rdata = ctrl_word(r_ctrl);
      TC_PRESET: bus.rdata = r_preset;
      TC_COUNT:  bus.rdata = r_count;
      default:   bus.rdata = 32'd0;
    endcase
  end

  assign bus.irq = r_irq;

endmodule
